// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the AXI4-Lite-to-APB bridge (master) and one
// register-file completer (slave).
interface apb_slave_regfile_if;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer holding NUM_REGS 32-bit registers with byte strobes, wait states,
// PSLVERR decode and read-only status mirrors. Optional macro: APB_SLV_PROT_CHECK_EN.
module apb_slave_regfile #(
  parameter int unsigned          NUM_REGS    = 16,
  parameter logic [31:0]          BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [31:0]          RESET_VAL   = 32'h0000_0000
) (
  input  logic                      s_apb_pclk,
  input  logic                      s_apb_presetn,
  apb_slave_regfile_if.slave        s_apb,
  input  logic [NUM_REGS*32-1:0]    hw_status,
  output logic [NUM_REGS*32-1:0]    reg_out
);

  localparam logic [31:0] SPAN      = 32'(NUM_REGS * 4);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  strb_q;
  logic        write_q;
  logic [31:0] regs_q [NUM_REGS];

  logic        setup, pready, complete;
  logic [31:0] off;
  logic [7:0]  idx;
  logic        illegal, is_ro, prot_err, wr_commit;
  logic [31:0] rd_word;

  assign setup    = s_apb.psel && !s_apb.penable;
  assign pready   = (state_q == ACCESS) && (wait_q == 4'd0);
  assign complete = (state_q == ACCESS) && s_apb.psel && s_apb.penable && pready;

  // NOTE: state registers use non-blocking assignments; the combinational
  // next-state logic below uses blocking ones with every output defaulted first
  // so no latch can be inferred.
  always_ff @(posedge s_apb_pclk or negedge s_apb_presetn) begin
    if (!s_apb_presetn) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // A setup cycle restarts the transfer from either state; psel low aborts.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (setup) begin
      state_d = ACCESS;
      wait_d  = WAIT_LOAD;
    end else if (state_q == ACCESS) begin
      if (!s_apb.psel || pready) state_d = IDLE;
      else                       wait_d  = wait_q - 4'd1;
    end
  end

  always_ff @(posedge s_apb_pclk or negedge s_apb_presetn) begin
    if (!s_apb_presetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
    end else if (setup) begin
      addr_q  <= s_apb.paddr;
      wdata_q <= s_apb.pwdata;
      strb_q  <= s_apb.pstrb;
      write_q <= s_apb.pwrite;
    end
  end

  assign off     = addr_q - BASE_ADDR;
  assign idx     = off[9:2];
  assign illegal = (addr_q < BASE_ADDR) || (off >= SPAN) || (addr_q[1:0] != 2'b00);

  always_comb begin
    is_ro   = 1'b0;
    rd_word = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (idx == 8'(i)) begin
        is_ro   = RO_MASK[i];
        rd_word = RO_MASK[i] ? hw_status[32*i +: 32] : regs_q[i];
      end
    end
  end

`ifdef APB_SLV_PROT_CHECK_EN
  logic priv_q;

  always_ff @(posedge s_apb_pclk or negedge s_apb_presetn) begin
    if (!s_apb_presetn)  priv_q <= 1'b0;
    else if (setup)      priv_q <= s_apb.pprot[0];
  end

  // Unprivileged writes to writable registers are refused; reads pass.
  assign prot_err = write_q && !is_ro && !priv_q;
`else
  assign prot_err = 1'b0;
`endif

  assign s_apb.pready  = pready;
  assign s_apb.pslverr = pready && (illegal || prot_err);
  assign s_apb.prdata  = (pready && !write_q && !illegal) ? rd_word : '0;

  // Read-only targets complete without error but never touch storage.
  assign wr_commit = complete && write_q && !illegal && !prot_err && !is_ro;

  // NOTE: the register bank is a set of flops, not a RAM, so every word is
  // reset; RAM-style storage would be left without a reset instead.
  always_ff @(posedge s_apb_pclk or negedge s_apb_presetn) begin
    if (!s_apb_presetn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= RESET_VAL;
    end else if (wr_commit) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (idx == 8'(i)) begin
          for (int k = 0; k < 4; k++) begin
            if (strb_q[k]) regs_q[i][8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 3 and 2 wait states) on a
// shared stimulus bus, table vectors, corner sequences and random traffic.
module tb_apb_slave_regfile;

`ifdef APB_SLV_PROT_CHECK_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [2:0]  pprot = '0;
  logic [3:0]  pstrb = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic        pready, pslverr;
  logic [31:0] prdata;

  logic [16*32-1:0] status0 = '0;
  logic [8*32-1:0]  status1 = '0;
  logic [4*32-1:0]  status2 = '0;
  logic [16*32-1:0] regout0;
  logic [8*32-1:0]  regout1;
  logic [4*32-1:0]  regout2;

  apb_slave_regfile_if if0 ();
  apb_slave_regfile_if if1 ();
  apb_slave_regfile_if if2 ();

  assign if0.psel = psel && (sel == 0);
  assign if1.psel = psel && (sel == 1);
  assign if2.psel = psel && (sel == 2);
  assign if0.paddr = paddr;   assign if1.paddr = paddr;   assign if2.paddr = paddr;
  assign if0.pprot = pprot;   assign if1.pprot = pprot;   assign if2.pprot = pprot;
  assign if0.penable = penable; assign if1.penable = penable; assign if2.penable = penable;
  assign if0.pwrite = pwrite; assign if1.pwrite = pwrite; assign if2.pwrite = pwrite;
  assign if0.pwdata = pwdata; assign if1.pwdata = pwdata; assign if2.pwdata = pwdata;
  assign if0.pstrb = pstrb;   assign if1.pstrb = pstrb;   assign if2.pstrb = pstrb;

  assign pready  = (sel == 0) ? if0.pready  : (sel == 1) ? if1.pready  : if2.pready;
  assign pslverr = (sel == 0) ? if0.pslverr : (sel == 1) ? if1.pslverr : if2.pslverr;
  assign prdata  = (sel == 0) ? if0.prdata  : (sel == 1) ? if1.prdata  : if2.prdata;

  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0),
                      .RO_MASK(16'h8008), .RESET_VAL(32'h0000_0000)) dut0 (
    .s_apb_pclk(clk), .s_apb_presetn(rst_n), .s_apb(if0),
    .hw_status(status0), .reg_out(regout0));

  apb_slave_regfile #(.NUM_REGS(8), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3),
                      .RO_MASK(8'h00), .RESET_VAL(32'h5A5A_0000)) dut1 (
    .s_apb_pclk(clk), .s_apb_presetn(rst_n), .s_apb(if1),
    .hw_status(status1), .reg_out(regout1));

  apb_slave_regfile #(.NUM_REGS(4), .BASE_ADDR(32'h0000_0040), .WAIT_STATES(2),
                      .RO_MASK(4'h0), .RESET_VAL(32'h1234_5678)) dut2 (
    .s_apb_pclk(clk), .s_apb_presetn(rst_n), .s_apb(if2),
    .hw_status(status2), .reg_out(regout2));

  // Per-instance configuration as seen by the reference model.
  int          nregs [3] = '{16, 8, 4};
  int          ws    [3] = '{0, 3, 2};
  logic [31:0] base  [3] = '{32'h1000, 32'h2000, 32'h0040};
  logic [31:0] rstv  [3] = '{32'h0, 32'h5A5A_0000, 32'h1234_5678};
  logic [15:0] ro    [3] = '{16'h8008, 16'h0000, 16'h0000};
  logic [31:0] mem   [3][16];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_word(input int s, input int i);
    return (s == 0) ? status0[32*i +: 32] : 32'h0;
  endfunction

  function automatic logic [31:0] regout_word(input int s, input int i);
    if (s == 0) return regout0[32*i +: 32];
    if (s == 1) return regout1[32*i +: 32];
    return regout2[32*i +: 32];
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++) mem[s][i] = rstv[s];
  endfunction

  // Reference: address window, alignment, read-only and privilege rules.
  function automatic void model_xfer(input int s, input bit wr, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] st,
                                     input logic [2:0] pr,
                                     output logic [31:0] exp_rd, output logic exp_err);
    longint off;
    int     i;
    exp_rd  = '0;
    exp_err = 1'b0;
    off = longint'(a) - longint'(base[s]);
    if (off < 0 || off >= longint'(nregs[s] * 4) || (a % 4) != 0) begin
      exp_err = 1'b1;
      return;
    end
    i = int'(off / 4);
    if (wr) begin
      if (ro[s][i]) return;
      if (PROT_ON && !pr[0]) begin
        exp_err = 1'b1;
        return;
      end
      for (int k = 0; k < 4; k++)
        if (st[k]) mem[s][i][8*k +: 8] = d[8*k +: 8];
    end else begin
      exp_rd = ro[s][i] ? status_word(s, i) : mem[s][i];
    end
  endfunction

  // One complete transfer; counts access cycles seen with pready low.
  task automatic apb_xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input logic [2:0] pr,
                          output logic [31:0] rd, output logic er, output int waits, output bit ok);
    bit quiet = 1'b1;
    @(negedge clk);
    sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = a; pwdata = d; pstrb = st; pprot = pr;
    @(negedge clk);
    penable = 1'b1;
    #1;
    waits = 0; ok = 1'b0; rd = '0; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pready === 1'b1) begin
        rd = prdata; er = pslverr; ok = 1'b1;
        break;
      end
      if (pslverr !== 1'b0 || prdata !== 32'h0) quiet = 1'b0;
      waits++;
      @(negedge clk);
      #1;
    end
    check("xfer_timeout", 32'(ok), 32'd1);
    check("quiet_while_waiting", 32'(quiet), 32'd1);
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    int          s;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] rd, m_rd;
  logic        er, m_er;
  int          waits;
  bit          ok;

  initial begin
    status0[32*3  +: 32] = 32'h0000_CAFE;
    status0[32*15 +: 32] = 32'hFEED_0015;
    model_reset();

    #12;
    check("rst_pready0", 32'(if0.pready), 32'd0);
    check("rst_prdata0", if0.prdata, 32'h0);
    check("rst_pslverr1", 32'(if1.pslverr), 32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < nregs[s]; i++)
        if (!ro[s][i]) check($sformatf("rst_regout_%0d_%0d", s, i), regout_word(s, i), rstv[s]);

    // Directed vectors with hand-derived expectations.
    vecs.push_back('{0, 1'b1, 32'h1004, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h1004, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h1004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h1008, 32'h1122_3344, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b1, 32'h1008, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h1008, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h100C, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h100C, 32'h0,         4'hF, 32'h0000_CAFE, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h1040, 32'h0,         4'hF, 32'h0,         1'b1});
    vecs.push_back('{0, 1'b1, 32'h1040, 32'h5555_5555, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{0, 1'b1, 32'h1002, 32'h1234_5678, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{0, 1'b0, 32'h1000, 32'h0,         4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h0FFC, 32'h0,         4'hF, 32'h0,         1'b1});
    vecs.push_back('{1, 1'b0, 32'h2000, 32'h0,         4'hF, 32'h5A5A_0000, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h201C, 32'h0102_0304, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h201C, 32'h0,         4'hF, 32'h0102_0304, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h2020, 32'h0,         4'hF, 32'h0,         1'b1});
    vecs.push_back('{2, 1'b0, 32'h004C, 32'h0,         4'hF, 32'h1234_5678, 1'b0});

    foreach (vecs[v]) begin
      apb_xfer(vecs[v].s, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].strb, 3'b001,
               rd, er, waits, ok);
      model_xfer(vecs[v].s, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].strb, 3'b001,
                 m_rd, m_er);
      check($sformatf("vec%0d_prdata", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_pslverr", v), 32'(er), 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_waits", v), 32'(waits), 32'(ws[vecs[v].s]));
    end
    @(negedge clk);
    check("regout0_w1", regout0[32*1 +: 32], 32'hDEAD_BEEF);
    check("regout0_w2", regout0[32*2 +: 32], 32'h11BB_33DD);
    check("regout0_w0_untouched", regout0[32*0 +: 32], 32'h0);

    // Unprivileged write to a writable register.
    apb_xfer(0, 1'b1, 32'h1010, 32'h1357_2468, 4'hF, 3'b000, rd, er, waits, ok);
    model_xfer(0, 1'b1, 32'h1010, 32'h1357_2468, 4'hF, 3'b000, m_rd, m_er);
    check("prot_wr_pslverr", 32'(er), 32'(PROT_ON));
    apb_xfer(0, 1'b0, 32'h1010, 32'h0, 4'hF, 3'b000, rd, er, waits, ok);
    check("prot_rd_value", rd, PROT_ON ? 32'h0 : 32'h1357_2468);
    check("prot_rd_pslverr", 32'(er), 32'd0);

    // Abort: psel drops during the wait phase of a write.
    @(negedge clk);
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h2004; pwdata = 32'hBAAD_BAAD; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    #1;
    check("abort_pready", 32'(pready), 32'd0);
    check("abort_no_update", regout1[32*1 +: 32], 32'h5A5A_0000);

    // Reset asserted during the access phase of a pending write.
    apb_xfer(2, 1'b1, 32'h0044, 32'h0BAD_F00D, 4'hF, 3'b001, rd, er, waits, ok);
    @(negedge clk);
    check("pre_rst_regout2_w1", regout2[32*1 +: 32], 32'h0BAD_F00D);
    sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0044; pwdata = 32'hCAFE_BABE; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pready", 32'(pready), 32'd0);
    check("midrst_regout2_w1", regout2[32*1 +: 32], 32'h1234_5678);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apb_xfer(2, 1'b0, 32'h0044, 32'h0, 4'hF, 3'b001, rd, er, waits, ok);
    check("midrst_read", rd, 32'h1234_5678);
    check("midrst_read_err", 32'(er), 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 240; n++) begin
      int          s;
      bit          wr;
      logic [31:0] a, d;
      logic [3:0]  st;
      logic [2:0]  pr;
      s  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      a  = base[s] - 32'd8 + 32'($urandom_range(0, nregs[s] * 4 + 15));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = $urandom;
      st = 4'($urandom);
      pr = 3'($urandom);
      apb_xfer(s, wr, a, d, st, pr, rd, er, waits, ok);
      model_xfer(s, wr, a, d, st, pr, m_rd, m_er);
      check($sformatf("rnd%0d_prdata", n), rd, m_rd);
      check($sformatf("rnd%0d_pslverr", n), 32'(er), 32'(m_er));
      check($sformatf("rnd%0d_waits", n), 32'(waits), 32'(ws[s]));
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < nregs[s]; i++)
        if (!ro[s][i]) check($sformatf("final_regout_%0d_%0d", s, i), regout_word(s, i), mem[s][i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
